// File: rtl/casc_counter_slice.sv
// Cascadable up/down counter slice. It has a synchronous parallel load, a
// programmable modulus, a combinational terminal-count output for chaining
// slices, and a sticky flag that records every wrap.
module casc_counter_slice #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MOD     = 64'd1 << WIDTH,
    parameter bit              CASCADE = 1'b1
) (
    input  logic             clk_pad,
    input  logic             rst_pad,
    input  logic             en_pad,
    input  logic             ld_pad,
    input  logic [WIDTH-1:0] d_pad,
    input  logic             cep_pad,
    input  logic             cet_pad,
    input  logic             up_pad,
    input  logic             clr_ovf_pad,
    output logic [WIDTH-1:0] q_pad,
    output logic             tc_pad,
    output logic             ovf_pad
);

    // Largest in-range count value. MOD never exceeds 2**WIDTH, so MOD-1 always fits in WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 64'd1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             countEn;
    logic             upWrap;
    logic             downWrap;
    logic             wrapTaken;
    logic [WIDTH-1:0] stepUp;
    logic [WIDTH-1:0] stepDown;
    logic [WIDTH-1:0] termValue;
    logic             atTerm;

    // Candidate next values for both directions, and the wrap conditions that select them
    always_comb begin
        countEn  = en_pad & ~ld_pad & cep_pad & cet_pad;
        upWrap   = (count_q >= MAX_VAL);
        downWrap = (count_q == '0);
        stepUp   = upWrap   ? '0      : count_q + WIDTH'(1);
        stepDown = downWrap ? MAX_VAL : count_q - WIDTH'(1);
    end

    // Next-state selection: a disabled slice holds, then load, then count; a wrap sets the sticky flag ahead of a clear
    always_comb begin
        count_d   = count_q;
        ovf_d     = ovf_q;
        wrapTaken = 1'b0;
        if (en_pad && ld_pad) begin
            count_d = d_pad;
        end else if (countEn) begin
            if (up_pad) begin
                count_d   = stepUp;
                wrapTaken = upWrap;
            end else begin
                count_d   = stepDown;
                wrapTaken = downWrap;
            end
        end
        if (wrapTaken) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_pad) begin
            ovf_d = 1'b0;
        end
    end

    // State registers with synchronous reset overriding every other input
    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // The terminal value depends on the current direction. It only looks at the registered count, so there is no path from d_pad.
    always_comb begin
        termValue = up_pad ? MAX_VAL : '0;
        atTerm    = (count_q == termValue);
    end

    generate
        if (CASCADE) begin : gTcGated
            assign tc_pad = cet_pad & atTerm;
        end else begin : gTcUngated
            assign tc_pad = atTerm;
        end
    endgenerate

    assign q_pad   = count_q;
    assign ovf_pad = ovf_q;

endmodule

// File: tb/tb_casc_counter_slice.sv
// Self-checking bench for casc_counter_slice. It drives a modulus-16 gated
// slice and a modulus-10 ungated slice from shared inputs. It also drives a
// separate pair of chained slices that should act as one 8-bit counter.
module tb_casc_counter_slice;

    logic       clk;
    logic       rst, en, ld, cep, cet, up, clr;
    logic [3:0] d;
    logic [3:0] q16, q10;
    logic       tc16, tc10, ovf16, ovf10;

    logic       cRst, cEn, cCep, cUp;
    logic [3:0] loQ, hiQ;
    logic       loTc, hiTc, loOvf, hiOvf;

    int checks = 0;
    int errors = 0;

    int m16q, m16ovf, m10q, m10ovf;
    int total;

    casc_counter_slice #(.WIDTH(4), .MOD(16), .CASCADE(1'b1)) dut16 (
        .clk_pad(clk), .rst_pad(rst), .en_pad(en), .ld_pad(ld), .d_pad(d),
        .cep_pad(cep), .cet_pad(cet), .up_pad(up), .clr_ovf_pad(clr),
        .q_pad(q16), .tc_pad(tc16), .ovf_pad(ovf16)
    );

    casc_counter_slice #(.WIDTH(4), .MOD(10), .CASCADE(1'b0)) dut10 (
        .clk_pad(clk), .rst_pad(rst), .en_pad(en), .ld_pad(ld), .d_pad(d),
        .cep_pad(cep), .cet_pad(cet), .up_pad(up), .clr_ovf_pad(clr),
        .q_pad(q10), .tc_pad(tc10), .ovf_pad(ovf10)
    );

    casc_counter_slice #(.WIDTH(4), .MOD(16), .CASCADE(1'b1)) casLo (
        .clk_pad(clk), .rst_pad(cRst), .en_pad(cEn), .ld_pad(1'b0), .d_pad(4'd0),
        .cep_pad(cCep), .cet_pad(1'b1), .up_pad(cUp), .clr_ovf_pad(1'b0),
        .q_pad(loQ), .tc_pad(loTc), .ovf_pad(loOvf)
    );

    casc_counter_slice #(.WIDTH(4), .MOD(16), .CASCADE(1'b1)) casHi (
        .clk_pad(clk), .rst_pad(cRst), .en_pad(cEn), .ld_pad(1'b0), .d_pad(4'd0),
        .cep_pad(cCep), .cet_pad(loTc), .up_pad(cUp), .clr_ovf_pad(1'b0),
        .q_pad(hiQ), .tc_pad(hiTc), .ovf_pad(hiOvf)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model of one slice for one clock edge, written directly from the counting rules
    task automatic modelEdge(input int modv, inout int q, inout int ovf,
                             input bit r, input bit e, input bit l, input bit p,
                             input bit t, input bit u, input bit c, input int dv);
        bit wrap;
        wrap = 1'b0;
        if (r) begin
            q   = 0;
            ovf = 0;
        end else begin
            if (e && l) begin
                q = dv;
            end else if (e && p && t) begin
                if (u) begin
                    if (q + 1 >= modv) begin q = 0; wrap = 1'b1; end
                    else q = q + 1;
                end else begin
                    if (q == 0) begin q = modv - 1; wrap = 1'b1; end
                    else q = q - 1;
                end
            end
            if (wrap) ovf = 1;
            else if (c) ovf = 0;
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".q16"},   {28'd0, q16}, m16q);
        checkVal({tag, ".ovf16"}, {31'd0, ovf16}, m16ovf);
        checkVal({tag, ".q10"},   {28'd0, q10}, m10q);
        checkVal({tag, ".ovf10"}, {31'd0, ovf10}, m10ovf);
    endtask

    // One cycle on the two independent slices: the combinational tc is checked before the edge, the registered state after it
    task automatic applyStimulus(input string tag, input bit r, input bit e, input bit l,
                                 input bit p, input bit t, input bit u, input bit c,
                                 input logic [3:0] dv);
        rst = r; en = e; ld = l; cep = p; cet = t; up = u; clr = c; d = dv;
        #1;
        checkVal({tag, ".tc16"}, {31'd0, tc16}, {31'd0, t & (m16q == (u ? 15 : 0))});
        checkVal({tag, ".tc10"}, {31'd0, tc10}, {31'd0, 1'(m10q == (u ? 9 : 0))});
        @(posedge clk);
        modelEdge(16, m16q, m16ovf, r, e, l, p, t, u, c, int'(dv));
        modelEdge(10, m10q, m10ovf, r, e, l, p, t, u, c, int'(dv));
        #1;
        checkOutput(tag);
    endtask

    // One cycle on the chained pair, modelled as a single 8-bit up/down counter
    task automatic cascStep(input string tag, input bit r, input bit e, input bit p, input bit u);
        int lo, hi;
        bit expLoTc;
        cRst = r; cEn = e; cCep = p; cUp = u;
        #1;
        lo = total % 16;
        hi = total / 16;
        expLoTc = (lo == (u ? 15 : 0));
        checkVal({tag, ".loTc"}, {31'd0, loTc}, {31'd0, expLoTc});
        checkVal({tag, ".hiTc"}, {31'd0, hiTc}, {31'd0, expLoTc & (hi == (u ? 15 : 0))});
        @(posedge clk);
        if (r) total = 0;
        else if (e && p) total = u ? (total + 1) % 256 : (total + 255) % 256;
        #1;
        checkVal({tag, ".q8"}, {24'd0, hiQ, loQ}, total);
    endtask

    // Directed sequence followed by randomized traffic
    initial begin
        rst = 1'b1; en = 1'b0; ld = 1'b0; cep = 1'b0; cet = 1'b0; up = 1'b1; clr = 1'b0; d = 4'd0;
        cRst = 1'b1; cEn = 1'b0; cCep = 1'b0; cUp = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m16q = 0; m16ovf = 0; m10q = 0; m10ovf = 0; total = 0;
        checkOutput("reset");

        // While held in reset in down mode, tc is asserted because the count is 0
        applyStimulus("rstDown", 1, 0, 1, 1, 1, 0, 0, 4'd9);

        // Sixteen up steps through the full range of the modulus-16 slice
        for (int i = 0; i < 16; i++) applyStimulus("up16", 0, 1, 0, 1, 1, 1, 0, 4'd0);
        checkVal("up16.wrapOvf", {31'd0, ovf16}, 32'd1);

        // Load 7, then count down across the zero boundary
        applyStimulus("ld7", 0, 1, 1, 0, 0, 0, 1, 4'd7);
        for (int i = 0; i < 9; i++) applyStimulus("down", 0, 1, 0, 1, 1, 0, 0, 4'd0);
        checkVal("down.q10", {28'd0, q10}, 32'd8);
        applyStimulus("clrOvf", 0, 1, 0, 0, 1, 0, 1, 4'd0);
        checkVal("clrOvf.ovf10", {31'd0, ovf10}, 32'd0);

        // A load wins over a count, and a disabled slice ignores a load
        applyStimulus("ldOverCnt", 0, 1, 1, 1, 1, 1, 0, 4'd5);
        checkVal("ldOverCnt.q16", {28'd0, q16}, 32'd5);
        applyStimulus("enOffLd", 0, 0, 1, 1, 1, 1, 0, 4'd9);
        checkVal("enOffLd.q16", {28'd0, q16}, 32'd5);

        // A wrap on the same edge as a clear request leaves the flag set
        applyStimulus("ld15", 0, 1, 1, 0, 0, 1, 1, 4'd15);
        applyStimulus("wrapClr", 0, 1, 0, 1, 1, 1, 1, 4'd0);
        checkVal("wrapClr.ovf16", {31'd0, ovf16}, 32'd1);

        // Reset overrides a load request even with the slice disabled; the next edge then loads
        applyStimulus("rstLd", 1, 0, 1, 1, 1, 1, 0, 4'd9);
        applyStimulus("ldAfterRst", 0, 1, 1, 0, 0, 1, 0, 4'd9);
        checkVal("ldAfterRst.q16", {28'd0, q16}, 32'd9);

        // Freeze with clear request: count held, flag cleared
        applyStimulus("ld0", 0, 1, 1, 0, 0, 0, 0, 4'd0);
        applyStimulus("wrapDn", 0, 1, 0, 1, 1, 0, 0, 4'd0);
        applyStimulus("frzClr", 0, 0, 0, 1, 1, 0, 1, 4'd0);

        // Randomized traffic, including loads of values above the modulus-10 range
        for (int i = 0; i < 300; i++) begin
            applyStimulus("rand",
                          $urandom_range(0, 31) == 0, $urandom_range(0, 7) != 0,
                          $urandom_range(0, 7) == 0,  $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0,  1'($urandom_range(0, 1)),
                          $urandom_range(0, 7) == 0,  4'($urandom_range(0, 15)));
        end

        // Chained pair: 300 up steps from zero, then random traffic
        cascStep("cReset", 1, 1, 1, 1);
        for (int i = 0; i < 300; i++) cascStep("cUp", 0, 1, 1, 1);
        checkVal("casc300", {24'd0, hiQ, loQ}, 32'd44);
        for (int i = 0; i < 200; i++) begin
            cascStep("cRand", $urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                     $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
